// File: rtl/mc_csr_pkg.sv
// Shared constants and types for the memory controller CSR AHB slave.
// Imported by the slave, its register file and the bench.
package mc_csr_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [7:0] CSR_OFS_0 = 8'h00;
  localparam logic [7:0] CSR_OFS_1 = 8'h04;
  localparam logic [7:0] CSR_OFS_2 = 8'h08;
  localparam logic [7:0] CSR_OFS_3 = 8'h0C;
  localparam logic [7:0] CSR_OFS_4 = 8'h10;
  localparam logic [7:0] CSR_OFS_5 = 8'h14;
  localparam logic [7:0] CSR_OFS_6 = 8'h18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RWAIT,
    ST_ERR1,
    ST_ERR2
  } csr_ahb_state_e;

  function automatic logic htrans_active(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/mc_csr_regfile.sv
// CSR storage, one-cycle write strobes and the read mux.
// Pure storage; all bus decode lives in mc_csr_ahb_slave.
module mc_csr_regfile #(
  parameter int NUM_REGS = 7,
  parameter int IW       = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [IW-1:0]            wr_idx_i,
  input  logic [31:0]              wr_data_i,
  input  logic [IW-1:0]            rd_idx_i,
  output logic [31:0]              rd_data_o,
  output logic [NUM_REGS-1:0][31:0] reg_o,
  output logic [NUM_REGS-1:0]      wr_o
);

  logic [NUM_REGS-1:0][31:0] reg_q;
  logic [NUM_REGS-1:0]       wr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= '0;
      wr_q  <= '0;
    end else begin
      wr_q <= '0;
      if (wr_en_i) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_idx_i == IW'(i)) begin
            reg_q[i] <= wr_data_i;
            wr_q[i]  <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx_i == IW'(i)) rd_data_o = reg_q[i];
    end
  end

  assign reg_o = reg_q;
  assign wr_o  = wr_q;

endmodule

// File: rtl/mc_csr_ahb_slave.sv
// AHB-Lite slave terminating word-sized CSR accesses for the memory
// controller; illegal beats get a two-cycle ERROR response.
module mc_csr_ahb_slave
  import mc_csr_pkg::*;
#(
  parameter int          NUM_REGS  = 7,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          READ_WAIT = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_ahb_hsel,
  input  logic [31:0]               i_ahb_haddr,
  input  logic                      i_ahb_hwrite,
  input  logic [1:0]                i_ahb_htrans,
  input  logic [2:0]                i_ahb_hsize,
  input  logic [2:0]                i_ahb_hburst,
  input  logic                      i_ahb_hreadyin,
  input  logic [31:0]               i_ahb_hwdata,
  output logic                      o_ahb_hready,
  output logic [1:0]                o_ahb_hresp,
  output logic [31:0]               o_ahb_hrdata,
  output logic                      o_ahb_hgrant,
  output logic [NUM_REGS-1:0][31:0] o_csr_reg,
  output logic [NUM_REGS-1:0]       o_csr_wr
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] WIN_BYTES = 32'(4 * NUM_REGS);

  csr_ahb_state_e state_q;
  logic [1:0]     wcnt_q;
  logic           hready_q;
  logic [1:0]     hresp_q;
  logic           hgrant_q;
  logic           dp_vld_q;
  logic           dp_wr_q;
  logic           dp_ok_q;
  logic [IW-1:0]  dp_idx_q;

  logic           acc;
  logic           legal;
  logic [31:0]    ofs;
  logic [IW-1:0]  a_idx;
  logic           wr_en;
  logic           rd_hit;
  logic [31:0]    rd_data;
  logic           unused_ok;

  // Offset wraps for addresses below the base, so one compare
  // covers both ends of the window.
  assign ofs   = i_ahb_haddr - BASE_ADDR;
  assign a_idx = ofs[IW+1:2];
  assign legal = (i_ahb_hsize == HSIZE_WORD) &&
                 (i_ahb_haddr[1:0] == 2'b00) &&
                 (ofs < WIN_BYTES);

  // hready_q is high exactly in IDLE/ERR2, where a new beat may start.
  assign acc = i_ahb_hsel & i_ahb_hreadyin &
               htrans_active(i_ahb_htrans) & hready_q;

  assign unused_ok = ^i_ahb_hburst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      hgrant_q <= 1'b0;
      dp_vld_q <= 1'b0;
      dp_wr_q  <= 1'b0;
      dp_ok_q  <= 1'b0;
      dp_idx_q <= '0;
    end else begin
      hgrant_q <= 1'b1;
      if (acc) begin
        dp_vld_q <= 1'b1;
        dp_wr_q  <= i_ahb_hwrite;
        dp_ok_q  <= legal;
        dp_idx_q <= a_idx;
      end else if (hready_q) begin
        dp_vld_q <= 1'b0;
      end
      unique case (state_q)
        ST_RWAIT: begin
          if (wcnt_q == 2'd0) begin
            state_q  <= ST_IDLE;
            hready_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q - 2'd1;
          end
        end
        ST_ERR1: begin
          state_q  <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_ERROR;
        end
        ST_IDLE, ST_ERR2: begin
          if (acc && !legal) begin
            state_q  <= ST_ERR1;
            hready_q <= 1'b0;
            hresp_q  <= HRESP_ERROR;
          end else if (acc && !i_ahb_hwrite && (READ_WAIT > 0)) begin
            state_q  <= ST_RWAIT;
            wcnt_q   <= 2'(READ_WAIT - 1);
            hready_q <= 1'b0;
            hresp_q  <= HRESP_OKAY;
          end else begin
            state_q  <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // Legal data phases only ever complete in IDLE.
  assign wr_en  = dp_vld_q & dp_wr_q & dp_ok_q & (state_q == ST_IDLE);
  assign rd_hit = dp_vld_q & ~dp_wr_q & dp_ok_q & (state_q == ST_IDLE);

  mc_csr_regfile #(
    .NUM_REGS (NUM_REGS),
    .IW       (IW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_idx_i  (dp_idx_q),
    .wr_data_i (i_ahb_hwdata),
    .rd_idx_i  (dp_idx_q),
    .rd_data_o (rd_data),
    .reg_o     (o_csr_reg),
    .wr_o      (o_csr_wr)
  );

  assign o_ahb_hready = hready_q;
  assign o_ahb_hresp  = hresp_q;
  assign o_ahb_hrdata = rd_hit ? rd_data : 32'h0;
  assign o_ahb_hgrant = hgrant_q;

endmodule

// File: doc/mc_csr_ahb_slave.md
# mc_csr_ahb_slave

AHB-Lite slave that terminates CSR accesses from the external AHB master (SRAM loader/host) and holds the memory controller's 32-bit configuration registers. It sits inside `mc_top` between the AHB port and the controller core, decoding the 0x0200_0000 CSR window. It drives per-register values and write strobes into the core. Single-beat, word-only transfers are supported; every other access gets a two-cycle ERROR response.

## Interface
- `NUM_REGS`, 7: number of 32-bit CSRs at offsets 0x00..0x18.
- `BASE_ADDR`, 32'h0200_0000: window base; must be aligned to `4*NUM_REGS` rounded up to a power of two.
- `READ_WAIT`, 0: wait states inserted on reads, range 0..3.
- `clk` in 1: AHB/CSR clock. One clock domain; the block has no CDC.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `i_ahb_hsel` in 1: slave select.
- `i_ahb_haddr` in 32: address.
- `i_ahb_hwrite` in 1: 1 = write.
- `i_ahb_htrans` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `i_ahb_hsize` in 3: transfer size; only 3'b010 is legal.
- `i_ahb_hburst` in 3: ignored; each beat is checked on its own.
- `i_ahb_hreadyin` in 1: bus-level HREADY.
- `i_ahb_hwdata` in 32: write data, valid in the data phase.
- `o_ahb_hready` out 1: slave ready.
- `o_ahb_hresp` out 2: 00 OKAY, 01 ERROR.
- `o_ahb_hrdata` out 32: read data.
- `o_ahb_hgrant` out 1: 0 in reset, constant 1 afterwards.
- `o_csr_reg` out `NUM_REGS`x32: current register values.
- `o_csr_wr` out `NUM_REGS`: one-cycle strobe when a register is written.

## Operation
- **Accept.** A transfer is accepted when `hsel & hreadyin & htrans[1]` is true at a rising edge.
- **Latched fields.** On accept, the block latches `haddr`, `hwrite` and the legality check.
- **Legality.** A transfer is legal when all of the following hold:
  - `hsize==3'b010`;
  - `haddr[1:0]==0`;
  - `BASE_ADDR <= haddr < BASE_ADDR+4*NUM_REGS`.
- **IDLE/BUSY, or hsel low.** No transfer; the following cycle returns a zero-wait OKAY.
- **FSM states.** IDLE, RWAIT, ERR1, ERR2.
  - IDLE: on accept of a legal read with `READ_WAIT>0`, go to RWAIT and load `wcnt=READ_WAIT-1`.
  - IDLE: on accept of an illegal transfer, go to ERR1.
  - IDLE: a legal write, or a legal read with `READ_WAIT==0`, stays in IDLE.
  - RWAIT: `hready=0`; decrement `wcnt`; return to IDLE when `wcnt==0`. The final data-phase cycle, with `hready=1` and data, is spent in IDLE.
  - ERR1: `hready=0`, `hresp=01`, then go to ERR2.
  - ERR2: `hready=1`, `hresp=01`; go to ERR1 again if a new illegal transfer is accepted, otherwise handle it as in IDLE.
- **Write.** At the end of a legal write data phase (`hready=1`):
  - register[idx] takes `hwdata`;
  - `o_csr_wr[idx]` pulses for the next cycle.
  - `idx = (haddr-BASE_ADDR)>>2`.
- **Read.** `hrdata` = register[idx] in the cycle where `hready=1`. It is 0 in all other cycles and for errored reads.
- **Errored transfers.** They never modify any register or pulse any strobe.

## Timing
- **Reset values.**
  - All registers 0; `o_csr_wr` 0.
  - `o_ahb_hready` 1, `o_ahb_hresp` 00, `o_ahb_hrdata` 0, `o_ahb_hgrant` 0.
  - FSM in IDLE.
- **Latency.**
  - Write: 0 wait states; the register updates at the edge that closes the data phase.
  - Read: `READ_WAIT` wait states.
  - Error: exactly one wait cycle plus one final cycle.
- **Back-to-back pipelining.** A write data phase overlapped with the address phase of a read to the same register returns the new value. This needs no forwarding, because the write commits before the read data phase.
- **Address sampling.** Address-phase inputs are sampled only when `hreadyin=1`. While this slave stalls (RWAIT/ERR1), the pending address phase is held and accepted at the stall release.
- **Reset mid-transfer.** `rst_n` low forces IDLE with the outputs above immediately (asynchronous). A partially completed write is discarded.
- **Same-register writes.** Consecutive writes to the same register: the last one wins, and a strobe fires for each.

## Structure
- **Package `mc_csr_pkg`** holds:
  - `HTRANS_*` and `HRESP_OKAY/ERROR` constants;
  - the CSR offset constants (`CSR_OFS_0..6`);
  - the FSM state enum `csr_ahb_state_e`.
- **Sub-module `mc_csr_regfile`** holds storage, the write strobes and the read mux. The AHB FSM and decode stay in `mc_csr_ahb_slave`.

## Test plan
- **Reset defaults.** Release reset, then read 0x0200_0000..0x0200_0018 → each returns 0, OKAY, no wait states.
- **Write/read all registers.** Write 0xDEAD_BEEF to 0x0200_0008, then read 0x0200_0008:
  - `o_csr_wr[2]` pulses once;
  - `o_csr_reg[2]=0xDEADBEEF`;
  - readback matches.
  - Repeat with 10 `$random` values across all 7 registers.
- **Pipelined write-then-read.** Write 0x1234_5678 to 0x0200_0004 immediately followed by a read of 0x0200_0004 → the read returns 0x1234_5678.
- **Out-of-range and misaligned addresses.**
  - Write to 0x0200_001C → hready 0 then 1, with hresp 01 on both cycles; no register changes.
  - Read of 0x0200_0002 → same ERROR sequence, hrdata 0.
- **Illegal size and IDLE.**
  - Byte write (hsize 000) to 0x0200_0000 → ERROR sequence; register 0 keeps its old value.
  - htrans IDLE with hsel=1 → OKAY, no strobe.
- **Wait states and reset mid-transfer.**
  - With `READ_WAIT=2`, read 0x0200_0010 → hready low for exactly 2 cycles, then data.
  - Assert `rst_n` during RWAIT → hready=1 immediately and all registers 0.
